// File: rtl/ws2812_pkg.sv
// Shared state encoding and default timing constants for the WS2812 serial transmitter.
// Timing defaults assume a 48 MHz clk_sb (1.25 us bit, 60 us end-of-frame latch).
package ws2812_pkg;

    localparam int BIT_CYC   = 60;
    localparam int T0H_CYC   = 19;
    localparam int T1H_CYC   = 38;
    localparam int RESET_CYC = 2880;
    localparam int PRIME_CYC = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ws2812_tx_if.sv
// Pixel-feeder handshake and serial output bundle of the WS2812 transmitter.
// The feeder side is the master; the transmitter is the slave.
interface ws2812_tx_if;

    logic        send_leds_n;
    logic [23:0] rgb_data_in;
    logic        ws2812_next_led;
    logic        ws2812_dout;
    logic        busy;

    modport master (
        output send_leds_n,
        output rgb_data_in,
        input  ws2812_next_led,
        input  ws2812_dout,
        input  busy
    );

    modport slave (
        input  send_leds_n,
        input  rgb_data_in,
        output ws2812_next_led,
        output ws2812_dout,
        output busy
    );

endinterface

// File: rtl/ws2812_bit_timer.sv
// Decodes the shared cycle counter into the high/low window of the current bit and the
// end-of-bit strobe. Illegal T0H/T1H/BIT orderings are rejected at elaboration.
module ws2812_bit_timer #(
    parameter int BIT_CYC = ws2812_pkg::BIT_CYC,
    parameter int T0H_CYC = ws2812_pkg::T0H_CYC,
    parameter int T1H_CYC = ws2812_pkg::T1H_CYC,
    parameter int CNT_W   = 6
) (
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic             bit_val,
    output logic             high,
    output logic             bit_done
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYC);

    if (!((T0H_CYC < T1H_CYC) && (T1H_CYC < BIT_CYC))) begin : g_bad_timing
        $error("ws2812_bit_timer: need T0H_CYC < T1H_CYC < BIT_CYC");
    end

    always_comb begin
        high     = en && (cnt < (bit_val ? T1H : T0H));
        bit_done = en && (cnt == BIT_LAST);
    end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: session FSM, 24-bit MSB-first shift register and pixel handshake.
// Define WS2812_TX_INVERT_EN to invert ws2812_dout (idle level 1) for an inverting level shifter.
module ws2812_tx #(
    parameter int BIT_CYC   = ws2812_pkg::BIT_CYC,
    parameter int T0H_CYC   = ws2812_pkg::T0H_CYC,
    parameter int T1H_CYC   = ws2812_pkg::T1H_CYC,
    parameter int RESET_CYC = ws2812_pkg::RESET_CYC,
    parameter int PRIME_CYC = ws2812_pkg::PRIME_CYC
) (
    input  logic        clk_sb,
    input  logic        reset,
    ws2812_tx_if.slave  bus
);

    import ws2812_pkg::*;

    localparam int CNT_MAX = max3(BIT_CYC, RESET_CYC, PRIME_CYC);
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYC - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYC - 1);

`ifdef WS2812_TX_INVERT_EN
    localparam logic DOUT_IDLE = 1'b1;
`else
    localparam logic DOUT_IDLE = 1'b0;
`endif

    // A one-cycle PRIME would put the start and load pulses back to back.
    if (PRIME_CYC < 2) begin : g_bad_prime
        $error("ws2812_tx: PRIME_CYC must be at least 2");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      sr_q, sr_d;
    logic [4:0]       bit_idx_q, bit_idx_d;
    logic             next_led_q, next_led_d;

    logic send_active;
    logic bit_high;
    logic bit_done;

    assign send_active = (state_q == SEND);

    ws2812_bit_timer #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .CNT_W   (CNT_W)
    ) u_bit_timer (
        .en       (send_active),
        .cnt      (cnt_q),
        .bit_val  (sr_q[23]),
        .high     (bit_high),
        .bit_done (bit_done)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        bit_idx_d  = bit_idx_q;
        next_led_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.send_leds_n) begin
                    state_d    = PRIME;
                    cnt_d      = '0;
                    next_led_d = 1'b1;
                end
            end
            PRIME: begin
                if (cnt_q == PRIME_LAST) begin
                    state_d    = SEND;
                    cnt_d      = '0;
                    sr_d       = bus.rgb_data_in;
                    bit_idx_d  = 5'd23;
                    next_led_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == 5'd0) begin
                        // Pixel boundary: the request level is only looked at here.
                        if (!bus.send_leds_n) begin
                            sr_d       = bus.rgb_data_in;
                            bit_idx_d  = 5'd23;
                            next_led_d = 1'b1;
                        end else begin
                            state_d = LATCH;
                        end
                    end else begin
                        sr_d      = {sr_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q - 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sb or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            bit_idx_q  <= '0;
            next_led_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            bit_idx_q  <= bit_idx_d;
            next_led_q <= next_led_d;
        end
    end

    assign bus.ws2812_dout     = bit_high ^ DOUT_IDLE;
    assign bus.ws2812_next_led = next_led_q;
    assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_ws2812_tx.sv
// Self-checking bench for ws2812_tx: per-window scoreboard of dout/next_led/busy against a
// cycle model built from the stimulus. Build with WS2812_TX_INVERT_EN to check the inverted line.
module tb_ws2812_tx;

    localparam int BIT   = 10;
    localparam int T0H   = 3;
    localparam int T1H   = 7;
    localparam int RST   = 20;
    localparam int PRIME = 4;

`ifdef WS2812_TX_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk_sb = 1'b0;
    logic reset;

    ws2812_tx_if bus_if ();

    ws2812_tx #(
        .BIT_CYC   (BIT),
        .T0H_CYC   (T0H),
        .T1H_CYC   (T1H),
        .RESET_CYC (RST),
        .PRIME_CYC (PRIME)
    ) u_dut (
        .clk_sb (clk_sb),
        .reset  (reset),
        .bus    (bus_if)
    );

    always #5 clk_sb = ~clk_sb;

    // One expected window: len cycles, bit i of each vector is cycle i (dout in active-high sense).
    typedef struct {
        string       tag;
        int          len;
        logic [31:0] dout;
        logic [31:0] nl;
        logic [31:0] busy;
    } win_t;

    win_t        exp_q[$];
    win_t        cur_w;
    int          mon_pos = 0;
    logic [31:0] act_d = '0;
    logic [31:0] act_n = '0;
    logic [31:0] act_b = '0;

    logic [23:0] words[$];
    int          feed_idx = -1;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    function automatic void push_win(input string tag, input int len, input logic [31:0] d,
                                     input logic [31:0] n, input logic [31:0] b);
        win_t w;
        w.tag  = tag;
        w.len  = len;
        w.dout = d;
        w.nl   = n;
        w.busy = b;
        exp_q.push_back(w);
    endfunction

    // Expected windows of one session, starting the cycle after send_leds_n is sampled low.
    function automatic void push_session(input int base, input int npix, input int idle_len);
        logic [23:0] w;
        int          h;
        push_win("prime", PRIME, 32'h0, 32'h1, mask(PRIME));
        for (int p = 0; p < npix; p++) begin
            w = words[base + p];
            for (int j = 0; j < 24; j++) begin
                h = w[23 - j] ? T1H : T0H;
                push_win($sformatf("pix%0d_bit%0d", base + p, 23 - j), BIT, mask(h),
                         (j == 0) ? 32'h1 : 32'h0, mask(BIT));
            end
        end
        push_win("latch", RST, 32'h0, 32'h0, mask(RST));
        if (idle_len > 0) push_win("idle", idle_len, 32'h0, 32'h0, 32'h0);
    endfunction

    // Pixel feeder: present the next word after every next_led pulse.
    always @(negedge clk_sb) begin
        if (bus_if.ws2812_next_led === 1'b1 && words.size() > 0) begin
            feed_idx++;
            bus_if.rgb_data_in = words[(feed_idx < words.size()) ? feed_idx : words.size() - 1];
        end
    end

    // Scoreboard monitor.
    always @(negedge clk_sb) begin
        if (exp_q.size() > 0) begin
            act_d[mon_pos[4:0]] = bus_if.ws2812_dout ^ INV;
            act_n[mon_pos[4:0]] = bus_if.ws2812_next_led;
            act_b[mon_pos[4:0]] = bus_if.busy;
            mon_pos++;
            cur_w = exp_q[0];
            if (mon_pos == cur_w.len) begin
                checks++;
                if ({act_d, act_n, act_b} !== {cur_w.dout, cur_w.nl, cur_w.busy}) begin
                    failures++;
                    $display("FAIL %s: got dout=%b next_led=%b busy=%b, want dout=%b next_led=%b busy=%b",
                             cur_w.tag, act_d, act_n, act_b, cur_w.dout, cur_w.nl, cur_w.busy);
                end
                void'(exp_q.pop_front());
                mon_pos = 0;
                act_d   = '0;
                act_n   = '0;
                act_b   = '0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_sb);
        #1;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 5000) begin
            @(posedge clk_sb);
            i++;
        end
        #1;
    endtask

    task automatic load_words(input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                              input int n);
        words.delete();
        words.push_back(w0);
        if (n > 1) words.push_back(w1);
        if (n > 2) words.push_back(w2);
        feed_idx           = -1;
        bus_if.rgb_data_in = w0;
    endtask

    // Drop send_leds_n, push the model, release it raise_at cycles into the session.
    task automatic run_session(input int npix, input int raise_at, input int idle_len);
        bus_if.send_leds_n = 1'b0;
        wait_cycles(1);
        push_session(0, npix, idle_len);
        wait_cycles(raise_at);
        bus_if.send_leds_n = 1'b1;
        drain();
    endtask

    task automatic test_reset();
        logic activity;
        reset              = 1'b1;
        bus_if.send_leds_n = 1'b1;
        bus_if.rgb_data_in = '0;
        #2;
        checks++;
        if ({bus_if.ws2812_dout, bus_if.ws2812_next_led, bus_if.busy} !== {INV, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got dout=%b next_led=%b busy=%b, want dout=%b next_led=0 busy=0",
                     bus_if.ws2812_dout, bus_if.ws2812_next_led, bus_if.busy, INV);
        end
        wait_cycles(3);
        reset    = 1'b0;
        activity = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_cycles(1);
            activity |= bus_if.busy | bus_if.ws2812_next_led | (bus_if.ws2812_dout ^ INV);
        end
        checks++;
        if (activity !== 1'b0) begin
            failures++;
            $display("FAIL reset_quiet: activity=%b with send_leds_n high, want 0", activity);
        end
    endtask

    task automatic test_single_pixel();
        load_words(24'hA50000, 24'h0, 24'h0, 1);
        run_session(1, 1, 2);
    endtask

    task automatic test_back_to_back();
        load_words(24'hFFFFFF, 24'h000000, 24'h800001, 3);
        run_session(3, PRIME + 2 * 24 * BIT + 50, 2);
    endtask

    task automatic test_release_mid_pixel();
        load_words(24'h123456, 24'h00FF00, 24'h0, 2);
        run_session(2, PRIME + 24 * BIT + 12 * BIT + 2, 3);
    endtask

    task automatic test_latch_ignore();
        load_words(24'h0F0F0F, 24'h0, 24'h0, 1);
        bus_if.send_leds_n = 1'b0;
        wait_cycles(1);
        push_session(0, 1, 4);
        wait_cycles(10);
        bus_if.send_leds_n = 1'b1;
        wait_cycles(240);
        bus_if.send_leds_n = 1'b0;
        wait_cycles(4);
        bus_if.send_leds_n = 1'b1;
        drain();
        checks++;
        if (bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL latch_ignore_idle: busy=%b, want 0", bus_if.busy);
        end
    endtask

    task automatic test_latch_hold();
        load_words(24'hC3C3C3, 24'h3C3C3C, 24'h0, 2);
        bus_if.send_leds_n = 1'b0;
        wait_cycles(1);
        push_session(0, 1, 1);
        push_session(1, 1, 2);
        wait_cycles(10);
        bus_if.send_leds_n = 1'b1;
        wait_cycles(240);
        bus_if.send_leds_n = 1'b0;
        wait_cycles(25);
        bus_if.send_leds_n = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid_bit();
        logic activity;
        load_words(24'hFFFFFF, 24'h0, 24'h0, 1);
        bus_if.send_leds_n = 1'b0;
        wait_cycles(1);
        push_session(0, 1, 0);
        wait_cycles(PRIME);
        checks++;
        if ({bus_if.ws2812_dout ^ INV, bus_if.ws2812_next_led, bus_if.busy} !== 3'b111) begin
            failures++;
            $display("FAIL pre_reset_active: got dout=%b next_led=%b busy=%b, want dout=%b next_led=1 busy=1",
                     bus_if.ws2812_dout, bus_if.ws2812_next_led, bus_if.busy, ~INV);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_if.ws2812_dout, bus_if.ws2812_next_led, bus_if.busy} !== {INV, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async: got dout=%b next_led=%b busy=%b, want dout=%b next_led=0 busy=0",
                     bus_if.ws2812_dout, bus_if.ws2812_next_led, bus_if.busy, INV);
        end
        exp_q.delete();
        mon_pos            = 0;
        act_d              = '0;
        act_n              = '0;
        act_b              = '0;
        bus_if.send_leds_n = 1'b1;
        wait_cycles(2);
        reset    = 1'b0;
        activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_cycles(1);
            activity |= bus_if.busy | bus_if.ws2812_next_led | (bus_if.ws2812_dout ^ INV);
        end
        checks++;
        if (activity !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_bit_quiet: activity=%b with send_leds_n high, want 0", activity);
        end
        load_words(24'h5A5A5A, 24'h0, 24'h0, 1);
        run_session(1, 1, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_release_mid_pixel();
        test_latch_ignore();
        test_latch_hold();
        test_reset_mid_bit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 Parameter BIT_CYC, 60, clk_sb cycles per data bit (1.25 us at 48 MHz).
REQ-002 Parameter T0H_CYC, 19, high cycles for a 0 bit.
REQ-003 Parameter T1H_CYC, 38, high cycles for a 1 bit.
REQ-004 Parameter RESET_CYC, 2880, low cycles of the end-of-frame latch (60 us).
REQ-005 Parameter PRIME_CYC, 4, wait cycles between the start pulse and the first pixel load.
REQ-006 clk_sb  input  1  block clock; one clock; all state on rising edge.
REQ-007 reset  input  1  reset is asynchronous and active-high.
REQ-008 send_leds_n  input  1  active-low session request from the pixel feeder.
REQ-009 rgb_data_in  input  24  next pixel word; transmitted bit 23 first.
REQ-010 ws2812_next_led  output  1  single-cycle pulse requesting the next pixel word.
REQ-011 ws2812_dout  output  1  serial WS2812 data line.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, PRIME, SEND and LATCH.
REQ-014 In IDLE, ws2812_dout SHALL be low; when send_leds_n is sampled 0, the next cycle SHALL show state PRIME and ws2812_next_led=1 for exactly one cycle.
REQ-015 PRIME SHALL last PRIME_CYC cycles; on its last cycle rgb_data_in SHALL be latched into a 24-bit shift register, ws2812_next_led SHALL pulse for one cycle, and the FSM SHALL enter SEND.
REQ-016 Each bit SHALL occupy exactly BIT_CYC cycles: ws2812_dout high for T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles, then low for the remainder.
REQ-017 Bits SHALL be sent MSB first; the first high cycle of bit 23 SHALL follow the load cycle immediately.
REQ-018 At the end of bit 0 (pixel boundary), if send_leds_n=0, rgb_data_in SHALL be loaded, ws2812_next_led SHALL pulse once, and the next pixel SHALL start with no gap cycle.
REQ-019 At a pixel boundary with send_leds_n=1, the FSM SHALL enter LATCH; send_leds_n rising mid-pixel SHALL NOT truncate the pixel in flight.
REQ-020 LATCH SHALL hold ws2812_dout low for RESET_CYC cycles, then return to IDLE; send_leds_n during LATCH SHALL be ignored and re-evaluated in IDLE.
REQ-021 ws2812_next_led SHALL be asserted only on the start cycle and on load cycles, and never on two consecutive cycles.
REQ-022 The cycle counter SHALL be wide enough for max(BIT_CYC, RESET_CYC, PRIME_CYC)-1 and SHALL wrap to 0 at each bit, prime or latch end.
REQ-023 Operation with T0H_CYC < T1H_CYC < BIT_CYC violated SHALL be unsupported; simulation SHALL flag it at elaboration.

Reset
REQ-024 reset=1 SHALL force IDLE, counters 0, shift register 0, ws2812_next_led=0, busy=0, and ws2812_dout to its idle level, asynchronously, including mid-pixel or mid-latch.
REQ-025 After reset release, the first action SHALL occur no earlier than the first clk_sb edge with send_leds_n=0.

Configuration
REQ-026 With WS2812_TX_INVERT_EN defined, ws2812_dout SHALL be the logical inverse of REQ-014..REQ-020 (idle/reset level 1), for an inverting level shifter.
REQ-027 Without WS2812_TX_INVERT_EN, ws2812_dout SHALL be non-inverted with idle/reset level 0.

Structure
REQ-028 Package ws2812_pkg SHALL hold the state encoding and the default timing constants (BIT_CYC, T0H_CYC, T1H_CYC, RESET_CYC, PRIME_CYC).
REQ-029 Sub-module ws2812_bit_timer SHALL generate the per-bit high/low window and the bit_done strobe from BIT_CYC/T0H_CYC/T1H_CYC; the FSM, shift register and handshake SHALL stay in ws2812_tx.

Verification (BIT_CYC=10, T0H_CYC=3, T1H_CYC=7, RESET_CYC=20, PRIME_CYC=4)
REQ-030 send_leds_n low in IDLE with rgb_data_in=24'hA50000 -> next_led pulse, 4 cycles later a load pulse, then dout high-times 7,3,7,3,3,7,3,7 then sixteen 3-cycle highs, each bit 10 cycles.
REQ-031 send_leds_n held low for 3 pixels (24'hFFFFFF, 24'h000000, 24'h800001) -> next_led pulses every 240 cycles, no gap between pixels, bit patterns match.
REQ-032 send_leds_n rises at bit 12 of pixel 2 -> pixel 2 completes, no further next_led, dout low for exactly 20 cycles, busy drops the cycle IDLE is entered.
REQ-033 reset asserted mid-bit during SEND -> dout, next_led and busy go to reset values without a clock edge; no activity until send_leds_n is next sampled low.
REQ-034 send_leds_n pulsed low during LATCH -> ignored; held low after LATCH ends -> new session starts from IDLE.
REQ-035 Build with WS2812_TX_INVERT_EN, repeat REQ-030 -> dout is the exact inverse and idles high after reset.
